// File: rtl/rx_commit_pkg.sv
// Shared types and constants for the RX frame commit controller.
package rx_commit_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        DROP
    } commit_state_t;

    typedef enum logic [1:0] {
        DR_ERROR,
        DR_RUNT,
        DR_OVERSIZE,
        DR_OVERFLOW
    } drop_reason_t;

endpackage

// File: rtl/rx_frame_commit_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count up on inc_i, hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// Store-and-forward write controller for the RX MAC frame buffer.
// Bytes are written speculatively; a frame becomes visible to the reader
// only when commit_ptr_o advances past it. Bad frames rewind wr_ptr.
// Optional macro RX_FRAME_STATS_EN adds good/runt/oversize counters and
// an overflow pulse.
module rx_frame_commit_ctrl
    import rx_commit_pkg::*;
#(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned CRC_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              error_pulse_i,
    input  logic [ADDR_W:0]   rd_ptr_i,
    output logic              buf_wr_en_o,
    output logic [ADDR_W-1:0] buf_wr_addr_o,
    output logic [7:0]        buf_wr_data_o,
    output logic [ADDR_W:0]   commit_ptr_o,
    output logic [10:0]       frame_len_o,
    output logic              frame_len_valid_o,
    output logic [CNT_W-1:0]  drop_count_o
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [CNT_W-1:0]  good_count_o,
    output logic [CNT_W-1:0]  runt_count_o,
    output logic [CNT_W-1:0]  oversize_count_o,
    output logic              overflow_pulse_o
`endif
);

    localparam logic [10:0]     MIN_LEN    = 11'(MIN_FRAME);
    localparam logic [10:0]     MAX_LEN    = 11'(MAX_FRAME);
    localparam logic [3:0]      TIMER_INIT = 4'(CRC_WAIT - 1);
    localparam logic [ADDR_W:0] FULL_DIST  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    commit_state_t     state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   start_q, start_d;
    logic [10:0]       len_q, len_d;
    logic [3:0]        timer_q, timer_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W:0]   commit_q, commit_d;
    logic [10:0]       flen_q, flen_d;
    logic              flv_q, flv_d;

    logic [3:0]        drop_vec;   // one-hot by drop_reason_t
    logic              start_new;
    logic [ADDR_W:0]   base;
    logic              full;

    assign full = ((wr_ptr_q - rd_ptr_i) == FULL_DIST);

    // Next-state: receive, finalise (commit or rewind), and frame start.
    // Finalise in CHECK and the start of the next frame share a cycle, so the
    // start logic runs after the case using the post-finalise base pointer.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        start_d   = start_q;
        len_d     = len_q;
        timer_d   = timer_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit_d  = commit_q;
        flen_d    = flen_q;
        flv_d     = 1'b0;
        drop_vec  = '0;
        start_new = 1'b0;
        base      = wr_ptr_q;

        case (state_q)
            IDLE: begin
                start_new = rx_valid_i;
            end
            RECV: begin
                if (error_pulse_i || (rx_valid_i && (full || (len_q == MAX_LEN)))) begin
                    if (error_pulse_i)      drop_vec[DR_ERROR]    = 1'b1;
                    else if (full)          drop_vec[DR_OVERFLOW] = 1'b1;
                    else                    drop_vec[DR_OVERSIZE] = 1'b1;
                    wr_ptr_d = start_q;
                    state_d  = DROP;
                end else if (rx_valid_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q[ADDR_W-1:0];
                    wr_data_d = rx_data_i;
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    len_d     = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                end else begin
                    timer_d = TIMER_INIT;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (error_pulse_i || rx_valid_i || (timer_q == '0)) begin
                    state_d = IDLE;
                    if (error_pulse_i || (len_q < MIN_LEN)) begin
                        if (error_pulse_i) drop_vec[DR_ERROR] = 1'b1;
                        else               drop_vec[DR_RUNT]  = 1'b1;
                        wr_ptr_d = start_q;
                        base     = start_q;
                    end else begin
                        commit_d = wr_ptr_q;
                        flen_d   = len_q;
                        flv_d    = 1'b1;
                    end
                    start_new = rx_valid_i;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            DROP: begin
                if (!rx_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_new) begin
            start_d   = base;
            wr_en_d   = 1'b1;
            wr_addr_d = base[ADDR_W-1:0];
            wr_data_d = rx_data_i;
            wr_ptr_d  = base + PTR_ONE;
            len_d     = 11'd1;
            state_d   = RECV;
        end
    end

    // State, pointers and registered RAM / commit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            start_q   <= '0;
            len_q     <= '0;
            timer_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            commit_q  <= '0;
            flen_q    <= '0;
            flv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            start_q   <= start_d;
            len_q     <= len_d;
            timer_q   <= timer_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            commit_q  <= commit_d;
            flen_q    <= flen_d;
            flv_q     <= flv_d;
        end
    end

    assign buf_wr_en_o       = wr_en_q;
    assign buf_wr_addr_o     = wr_addr_q;
    assign buf_wr_data_o     = wr_data_q;
    assign commit_ptr_o      = commit_q;
    assign frame_len_o       = flen_q;
    assign frame_len_valid_o = flv_q;

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (|drop_vec),
        .clr_i   (1'b0),
        .count_o (drop_count_o)
    );

`ifdef RX_FRAME_STATS_EN
    logic ovf_q;

    // One-cycle pulse for each full-buffer drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= drop_vec[DR_OVERFLOW];
    end

    assign overflow_pulse_o = ovf_q;

    sat_counter #(.WIDTH(CNT_W)) u_good_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(flv_d), .clr_i(1'b0), .count_o(good_count_o)
    );
    sat_counter #(.WIDTH(CNT_W)) u_runt_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(drop_vec[DR_RUNT]), .clr_i(1'b0), .count_o(runt_count_o)
    );
    sat_counter #(.WIDTH(CNT_W)) u_over_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(drop_vec[DR_OVERSIZE]), .clr_i(1'b0), .count_o(oversize_count_o)
    );
`endif

endmodule
